// File: rtl/opmux_pkg.sv
// opmux_pkg: shared definitions for the opmux_rr operand multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the mode input
//   MAX_NCH              : largest supported channel count
//   rr_pick_t / rr_first : round-robin first-set search used by rr_arbiter
package opmux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int MAX_NCH = 16;

    typedef struct packed {
        logic       any;
        logic [3:0] idx;
    } rr_pick_t;

    // Find the first set bit of req, scanning upward from ptr+1 and wrapping
    // modulo nch. nch is always an elaboration-time constant at the call site,
    // so the loop and the modulo reduce to fixed logic.
    function automatic rr_pick_t rr_first(input logic [MAX_NCH-1:0] req,
                                          input logic [3:0]         ptr,
                                          input int                 nch);
        rr_pick_t   r;
        logic [3:0] c;
        r = '0;
        for (int k = 1; k <= MAX_NCH; k++) begin
            c = 4'((int'(ptr) + k) % nch);
            if ((k <= nch) && !r.any && req[c]) begin
                r.any = 1'b1;
                r.idx = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req       : per-channel request vector
//   ptr       : index of the last granted channel (search starts at ptr+1)
//   grant_idx : index of the granted channel (valid only when grant_any)
//   grant_any : at least one request is present
module rr_arbiter #(
    parameter int NCH  = 4,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_any
);
    import opmux_pkg::*;

    rr_pick_t pick;

    always_comb begin
        pick = rr_first(MAX_NCH'(req), 4'(ptr), NCH);
    end

    assign grant_any = pick.any;
    assign grant_idx = SELW'(pick.idx);

endmodule

// File: rtl/opmux_rr.sv
// opmux_rr: registered N-channel operand multiplexer with fixed or
// round-robin selection and a single output register stage.
//   clk, rst   : clock, asynchronous active-high reset
//   mode       : 0 = fixed (use sel), 1 = round-robin
//   sel        : channel index used in fixed mode
//   in_data    : channel k at bits [k*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready (one-hot or zero)
//   out_data   : registered selected data
//   out_ch     : channel that produced out_data
//   out_valid  : output register holds data
//   out_ready  : downstream accepts out_data
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high on that interface; valid never depends on ready.
module opmux_rr #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]     in_valid,
    output logic [NCH-1:0]     in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    output logic               out_valid,
    input  logic               out_ready
);
    import opmux_pkg::*;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q,   out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q,      ptr_d;

    logic [WIDTH-1:0] ch_data [NCH];
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;
    logic [SELW-1:0]  grant_idx;
    logic             grant_any;
    logic             sel_ok;
    logic             load;
    logic             xfer;

    for (genvar k = 0; k < NCH; k++) begin : g_split
        assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
    end

    rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant_idx (rr_idx),
        .grant_any (rr_any)
    );

    always_comb begin
        load      = !out_valid_q || out_ready;
        // sel can exceed NCH-1 when NCH is not a power of two.
        sel_ok    = {1'b0, sel} < (SELW+1)'(NCH);
        grant_any = (mode == MODE_RR) ? rr_any : sel_ok;
        grant_idx = (mode == MODE_RR) ? rr_idx : sel;

        in_ready = '0;
        if (grant_any && load) begin
            in_ready[grant_idx] = 1'b1;
        end
        xfer = grant_any && load && in_valid[grant_idx];

        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = ch_data[grant_idx];
                out_ch_d   = grant_idx;
            end
        end
        if (xfer && (mode == MODE_RR)) begin
            ptr_d = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            // Last-granted = NCH-1 gives channel 0 first priority.
            ptr_q       <= SELW'(NCH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_opmux_rr.sv
module tb_opmux_rr;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         mode = 1'b0;
  logic [1:0]   sel = '0;
  logic [127:0] in_data = '0;
  logic [3:0]   in_valid = '0;
  logic         out_ready = 1'b0;

  logic [3:0]   in_ready4;
  logic [31:0]  out_data4;
  logic [1:0]   out_ch4;
  logic         out_valid4;

  logic [2:0]   in_ready3;
  logic [31:0]  out_data3;
  logic [1:0]   out_ch3;
  logic         out_valid3;

  int total = 0;
  int bad = 0;

  opmux_rr #(.WIDTH(32), .NCH(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
    .out_data(out_data4), .out_ch(out_ch4), .out_valid(out_valid4),
    .out_ready(out_ready)
  );

  opmux_rr #(.WIDTH(32), .NCH(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data[95:0]), .in_valid(in_valid[2:0]), .in_ready(in_ready3),
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(out_ready)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: grant rule from plain arithmetic
  function automatic int m_grant(int nch, bit md, int s, logic [3:0] v, int p);
    if (!md) return (s < nch) ? s : -1;
    for (int k = 1; k <= nch; k++) begin
      int c;
      c = (p + k) % nch;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  bit          m_ov [2];
  logic [31:0] m_od [2];
  int          m_och [2];
  int          m_ptr [2];
  bit          n_ov [2];
  logic [31:0] n_od [2];
  int          n_och [2];
  int          n_ptr [2];

  // compare process: check every cycle on the falling edge, commit model on rising edge
  always begin
    int nch, g, p, och;
    bit ov, ld, xf;
    logic [31:0] od;
    logic [15:0] er, ar;
    logic [31:0] ad;
    logic [1:0]  ac;
    logic        av;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      nch = (i == 0) ? 4 : 3;
      if (rst) begin
        ov = 0; od = '0; och = 0; p = nch - 1;
      end else begin
        ov = m_ov[i]; od = m_od[i]; och = m_och[i]; p = m_ptr[i];
      end
      ld = !ov || out_ready;
      g = m_grant(nch, mode, int'(sel), (i == 0) ? in_valid : {1'b0, in_valid[2:0]}, p);
      er = (g >= 0 && ld) ? (16'd1 << g) : 16'd0;
      xf = (g >= 0) && ld && in_valid[g];
      if (i == 0) begin ar = 16'(in_ready4); ad = out_data4; ac = out_ch4; av = out_valid4; end
      else        begin ar = 16'(in_ready3); ad = out_data3; ac = out_ch3; av = out_valid3; end
      chk($sformatf("model_in_ready[%0d]", i), 64'(ar), 64'(er));
      chk($sformatf("model_out_valid[%0d]", i), 64'(av), 64'(ov));
      chk($sformatf("model_out_data[%0d]", i), 64'(ad), 64'(od));
      chk($sformatf("model_out_ch[%0d]", i), 64'(ac), 64'(och));
      n_ov[i] = ov; n_od[i] = od; n_och[i] = och; n_ptr[i] = p;
      if (ld) n_ov[i] = xf;
      if (xf) begin
        n_od[i] = in_data[g*32 +: 32];
        n_och[i] = g;
        if (mode) n_ptr[i] = g;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_ov[i] = 0; m_od[i] = '0; m_och[i] = 0; m_ptr[i] = (i == 0) ? 3 : 2;
      end else begin
        m_ov[i] = n_ov[i]; m_od[i] = n_od[i]; m_och[i] = n_och[i]; m_ptr[i] = n_ptr[i];
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  int exp_seq [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    #1 rst = 1'b1;
    step();
    at_neg();
    chk("reset_out_valid", 64'(out_valid4), 64'd0);
    chk("reset_out_data", 64'(out_data4), 64'd0);
    step();
    rst = 1'b0;

    // fixed mode, sel=2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data[2*32 +: 32] = 32'hDEADBEEF;
    at_neg();
    chk("fixed_in_ready", 64'(in_ready4), 64'b0100);
    step();
    at_neg();
    chk("fixed_out_data", 64'(out_data4), 64'hDEADBEEF);
    chk("fixed_out_ch", 64'(out_ch4), 64'd2);
    chk("fixed_out_valid", 64'(out_valid4), 64'd1);

    // round robin, all valid
    step();
    mode = 1'b1; in_valid = 4'b1111;
    for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'hA000_0000 + k;
    for (int i = 0; i < 6; i++) begin
      step();
      at_neg();
      chk($sformatf("rr_seq[%0d]", i), 64'(out_ch4), 64'(exp_seq[i]));
    end

    // round robin, only channel 3, then all
    step();
    in_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step();
      at_neg();
      chk($sformatf("rr_only3[%0d]", i), 64'(out_ch4), 64'd3);
    end
    step();
    in_valid = 4'b1111;
    step();
    at_neg();
    chk("rr_wrap_to0", 64'(out_ch4), 64'd0);

    // stall
    step();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data[31:0] = 32'h11;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data[31:0] = 32'h5000 + i;
      at_neg();
      chk($sformatf("stall_data[%0d]", i), 64'(out_data4), 64'h11);
      chk($sformatf("stall_ready[%0d]", i), 64'(in_ready4), 64'd0);
      step();
    end
    out_ready = 1'b1; in_data[31:0] = 32'h22;
    at_neg();
    chk("unstall_in_ready", 64'(in_ready4), 64'b0001);
    step();
    at_neg();
    chk("unstall_data", 64'(out_data4), 64'h22);
    chk("unstall_valid", 64'(out_valid4), 64'd1);

    // out-of-range sel on the three-channel instance
    step();
    sel = 2'd3; in_valid = 4'b1111;
    at_neg();
    chk("oor_in_ready", 64'(in_ready3), 64'd0);
    step();
    at_neg();
    chk("oor_out_valid", 64'(out_valid3), 64'd0);

    // reset during a stall
    step();
    sel = 2'd1; in_valid = 4'b0010; in_data[63:32] = 32'h33;
    step();
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(out_valid4), 64'd0);
    chk("rst_mid_data", 64'(out_data4), 64'd0);
    chk("rst_mid_ch", 64'(out_ch4), 64'd0);
    step();
    step();
    rst = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    step();
    at_neg();
    chk("post_rst_first_ch", 64'(out_ch4), 64'd0);
    chk("post_rst_first_valid", 64'(out_valid4), 64'd1);

    // randomized phase, checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      mode = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = $urandom;
    end
    step();
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opmux_rr.md
# opmux_rr

Parametrised, registered N-channel operand multiplexer for the ALU datapath; it generalises the 2:1 32-bit operand select to NCH channels of WIDTH bits. Each channel and the output use valid/ready handshakes. Selection is either fixed, using a `sel` input, or round-robin among requesting channels, chosen by a mode input. One output register stage sits between the operand sources and the ALU input latch.

## Interface
- `WIDTH`, 32: data width per channel.
- `NCH`, 4: number of input channels; legal range is 2..16.
- `SELW`, `$clog2(NCH)`: width of the select and channel-ID fields (derived).

- `clk`, in, 1: single clock; all state is on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `mode`, in, 1: 0 = FIXED (use `sel`); 1 = RR (round-robin).
- `sel`, in, SELW: channel index used in FIXED mode.
- `in_data`, in, NCH*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`, in, NCH: per-channel valid.
- `in_ready`, out, NCH: per-channel ready; at most one bit is high in any cycle.
- `out_data`, out, WIDTH: registered selected data.
- `out_ch`, out, SELW: index of the channel that produced `out_data`.
- `out_valid`, out, 1: the output register holds data.
- `out_ready`, in, 1: the downstream consumer accepts the data.

## Operation
- Load enable: `load = !out_valid || out_ready`.
- Grant channel g (combinational):
  - FIXED: g = `sel`. If `sel` ≥ NCH, there is no grant.
  - RR: g is the first channel with `in_valid` set, searching upward from `ptr+1` modulo NCH.
- `in_ready[g] = load`, and only when a grant exists. All other `in_ready` bits are 0.
- Transfer on channel g = `in_valid[g] && in_ready[g]`. On a transfer:
  - `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`.
  - In RR mode, `ptr <= g`.
- If `load` is high and there is no transfer, `out_valid <= 0`. `out_data` and `out_ch` hold their previous values.
- If `load` is low, the output register holds `out_data`, `out_ch` and `out_valid` exactly.
- `ptr` updates only on RR transfers. FIXED-mode transfers leave it unchanged.
- A change of `mode` or `sel` takes effect in the same cycle for the grant. It never disturbs data already held in the output register.
- In FIXED mode, channels other than `sel` are never granted, whatever their `in_valid` state.
- In RR mode, when only one channel is valid, that channel wins on every cycle, including back-to-back.
- Out-of-range `sel` in FIXED mode:
  - no transfer occurs and all `in_ready` bits are 0;
  - if `load` is high, `out_valid` clears.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=NCH-1 (so channel 0 has first priority).
- Reset is asserted asynchronously. On release, the first transfer is possible on the first rising edge where `rst` is low.
- Latency is 1 cycle: input accepted at edge t appears on `out_data`/`out_valid` after edge t.
- Throughput is one transfer per cycle while `out_ready` stays high.
- `in_ready` depends combinationally on `out_ready`, `mode`, `sel`, `in_valid` (RR mode only) and state. There is no path from `in_data` to `in_ready`.
- Simultaneous drain and fill: when `out_valid` and `out_ready` are high and a new transfer occurs, the register is replaced in the same edge with no bubble.
- Reset during a stalled transfer discards the held data, and `out_valid` drops immediately.
- RR fairness: a continuously valid channel waits at most NCH-1 grants.

## Structure
- Package `opmux_pkg`:
  - `MODE_FIXED` = 1'b0, `MODE_RR` = 1'b1;
  - a function for the round-robin first-set search.
- Sub-module `rr_arbiter`, parameter NCH:
  - inputs: `req[NCH]`, `ptr`;
  - outputs: `grant_idx`, `grant_any`;
  - purely combinational.
- The top level owns `ptr`, the output register and the handshake logic.

## Test plan
- Reset, FIXED mode, `sel`=2, `in_valid`=4'b0100, `in_data[2]`=32'hDEADBEEF, `out_ready`=1 → one cycle later `out_data`=DEADBEEF, `out_ch`=2, `out_valid`=1. `in_ready` was 4'b0100.
- RR mode, all four valid, `out_ready`=1 for 6 cycles → `out_ch` sequence is 0,1,2,3,0,1.
- Stall: `out_valid`=1 holding 32'h11, `out_ready`=0 for 3 cycles while `in_data` changes → `out_data` stays 32'h11 and `in_ready`=0 throughout. Raising `out_ready` accepts the next word with no bubble.
- RR mode, only channel 3 valid for 3 cycles, then all valid → `out_ch` is 3,3,3, then 0 (search starts from `ptr+1` wrapped).
- FIXED mode, `sel`=3 with NCH=3 and all valid → no transfer, `in_ready`=0, `out_valid` is 0 after one cycle.
- Assert `rst` mid-stall with `out_valid`=1 → `out_valid`, `out_data` and `out_ch` are 0 before the next edge. After release, channel 0 is granted first in RR mode.
